// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, defaults and helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam int KP_ROWS           = 4;
    localparam int KP_COLS           = 4;
    localparam int KP_SCAN_CYCLES    = 24000;
    localparam int KP_DEBOUNCE_SCANS = 20;

    function automatic int kp_code_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - 2-FF synchroniser for the raw column pins, resets to all ones (released)
module keypad_col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with press/release debounce and one-cycle key strobe
// Optional KEYPAD_GHOST_REJECT_EN: samples with two or more low columns are treated as invalid.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int  ROWS           = KP_ROWS,
    parameter int  COLS           = KP_COLS,
    parameter int  SCAN_CYCLES    = KP_SCAN_CYCLES,
    parameter int  DEBOUNCE_SCANS = KP_DEBOUNCE_SCANS,
    localparam int KW             = kp_code_w(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ROWS-1:0] rows_n,
    input  logic [COLS-1:0] cols_n,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int DW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);

    scan_state_t     r_state;
    logic [DW-1:0]   r_dwell;
    logic [DBW-1:0]  r_deb;
    logic [RW-1:0]   r_row_idx;
    logic [ROWS-1:0] r_rows_n;
    logic [RW-1:0]   r_cand_row;
    logic [CW-1:0]   r_cand_col;
    logic [KW-1:0]   r_key_code;
    logic            r_key_valid;
    logic            r_key_held;

    logic [COLS-1:0] w_cols_s;
    logic [COLS-1:0] w_low;
    logic            w_any;
    logic            w_invalid;
    logic [CW-1:0]   w_sel;
    logic            w_sample;
    logic            w_cand_low;
    logic [DBW-1:0]  w_deb_inc;
    logic [RW-1:0]   w_next_row;
    logic [ROWS-1:0] w_next_rows_n;
    logic [KW-1:0]   w_code_now;
    logic [KW-1:0]   w_code_cand;

    keypad_col_sync #(.WIDTH(COLS)) u_col_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (cols_n),
        .o_sync  (w_cols_s)
    );

    assign w_low      = ~w_cols_s;
    assign w_any      = |w_low;
    assign w_sample   = (r_dwell == DW'(SCAN_CYCLES - 1));
    assign w_cand_low = w_low[r_cand_col];
    assign w_deb_inc  = r_deb + DBW'(1);

`ifdef KEYPAD_GHOST_REJECT_EN
    assign w_invalid  = |(w_low & (w_low - COLS'(1)));
`else
    assign w_invalid  = 1'b0;
`endif

    // Lowest-index low column wins.
    always_comb begin
        w_sel = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_low[c]) w_sel = CW'(c);
        end
    end

    assign w_next_row    = (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + RW'(1);
    assign w_next_rows_n = ~(ROWS'(1) << w_next_row);
    assign w_code_now    = KW'(r_row_idx) * KW'(COLS) + KW'(w_sel);
    assign w_code_cand   = KW'(r_cand_row) * KW'(COLS) + KW'(r_cand_col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCAN;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_row_idx   <= '0;
            r_rows_n    <= ~ROWS'(1);
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_dwell     <= w_sample ? '0 : r_dwell + DW'(1);
            if (w_sample) begin
                case (r_state)
                    SCAN: begin
                        if (w_any && !w_invalid) begin
                            r_cand_row <= r_row_idx;
                            r_cand_col <= w_sel;
                            r_deb      <= DBW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_key_code  <= w_code_now;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_state     <= HELD;
                            end else begin
                                r_state <= DEBOUNCE;
                            end
                        end else begin
                            r_row_idx <= w_next_row;
                            r_rows_n  <= w_next_rows_n;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_cand_low && !w_invalid) begin
                            if (w_deb_inc == DBW'(DEBOUNCE_SCANS)) begin
                                r_key_code  <= w_code_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_state     <= HELD;
                            end
                            r_deb <= w_deb_inc;
                        end else begin
                            r_deb     <= '0;
                            r_state   <= SCAN;
                            r_row_idx <= w_next_row;
                            r_rows_n  <= w_next_rows_n;
                        end
                    end
                    HELD: begin
                        // Only the accepted column matters here; other keys in the row are ignored.
                        if (!w_cand_low) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                r_key_held <= 1'b0;
                                r_deb      <= '0;
                                r_state    <= SCAN;
                                r_row_idx  <= w_next_row;
                                r_rows_n   <= w_next_rows_n;
                            end else begin
                                r_deb   <= DBW'(1);
                                r_state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!w_cand_low) begin
                            if (w_deb_inc == DBW'(DEBOUNCE_SCANS)) begin
                                r_key_held <= 1'b0;
                                r_deb      <= '0;
                                r_state    <= SCAN;
                                r_row_idx  <= w_next_row;
                                r_rows_n   <= w_next_rows_n;
                            end else begin
                                r_deb <= w_deb_inc;
                            end
                        end else begin
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign rows_n    = r_rows_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench: keypad model, strobe scoreboard, vector table
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int total = 0;
    int bad   = 0;

    logic       p_on = 1'b0;
    logic [1:0] p_row = 2'd0;
    logic [3:0] p_mask = 4'd0;

    int exp_q[$];
    logic prev_valid = 1'b0;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_CYCLES(8), .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk), .reset(reset), .rows_n(rows_n), .cols_n(cols_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: pressed switches pull their columns low only while their row is driven.
    always_comb cols_n = (p_on && rows_n[p_row] == 1'b0) ? ~p_mask : 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        int n = 0;
        while (key_held !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, key_held}, {31'd0, v});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (key_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected: key_code=%0d want no strobe", key_code);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (key_code !== 4'(e)) begin
                        bad++;
                        $display("FAIL strobe_code: got %0d want %0d", key_code, e);
                    end
                end
                if (prev_valid) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_back_to_back: got two consecutive strobes want one");
                end
            end
            prev_valid = key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    typedef struct {
        logic [1:0] row;
        logic [3:0] mask;
        logic       strobe;
        int         code;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [3:0] exp_rows;
        logic [3:0] seen;

        vecs[0] = '{row: 2'd2, mask: 4'b0010, strobe: 1'b1, code: 9};
        vecs[1] = '{row: 2'd0, mask: 4'b1000, strobe: 1'b1, code: 3};
`ifdef KEYPAD_GHOST_REJECT_EN
        vecs[2] = '{row: 2'd1, mask: 4'b0110, strobe: 1'b0, code: 0};
`else
        vecs[2] = '{row: 2'd1, mask: 4'b0110, strobe: 1'b1, code: 5};
`endif
        vecs[3] = '{row: 2'd3, mask: 4'b0001, strobe: 1'b1, code: 12};
        vecs[4] = '{row: 2'd1, mask: 4'b0100, strobe: 1'b1, code: 6};

        // Reset state and free-running row scan.
        repeat (3) @(negedge clk);
        check("rst_rows_n", {28'd0, rows_n}, 32'hE);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_held", {31'd0, key_held}, 32'd0);
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_rows = ~(4'b0001 << ((k / 8) % 4));
            check($sformatf("scan_rows_k%0d", k), {28'd0, rows_n}, {28'd0, exp_rows});
        end
        check("scan_key_held", {31'd0, key_held}, 32'd0);

        // Press bounce: row 0 col 3 seen for one sample only, then a stable press.
        while (rows_n !== 4'b1110) @(negedge clk);
        p_row = 2'd0; p_mask = 4'b1000; p_on = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        p_on = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_no_held", {31'd0, key_held}, 32'd0);
        exp_q.push_back(3);
        p_on = 1'b1;
        wait_held(1'b1, 200, "bounce_held_rise");
        check("bounce_code", {28'd0, key_code}, 32'd3);
        p_on = 1'b0;
        wait_held(1'b0, 200, "bounce_held_fall");
        check("bounce_q_empty", exp_q.size(), 32'd0);

        // Release bounce on key 9: one released sample, re-press, then a real release.
        p_row = 2'd2; p_mask = 4'b0010; p_on = 1'b1;
        exp_q.push_back(9);
        wait_held(1'b1, 200, "rbounce_held_rise");
        p_on = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        p_on = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rbounce_still_held", {31'd0, key_held}, 32'd1);
        p_on = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("rbounce_held_2_released", {31'd0, key_held}, 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rbounce_held_3_released", {31'd0, key_held}, 32'd0);
        check("rbounce_next_row", {28'd0, rows_n}, 32'h7);
        check("rbounce_q_empty", exp_q.size(), 32'd0);

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            p_row = vecs[i].row; p_mask = vecs[i].mask; p_on = 1'b1;
            exp_rows = ~(4'b0001 << vecs[i].row);
            if (vecs[i].strobe) begin
                exp_q.push_back(vecs[i].code);
                wait_held(1'b1, 200, $sformatf("v%0d_held_rise", i));
                check($sformatf("v%0d_code", i), {28'd0, key_code}, vecs[i].code);
                check($sformatf("v%0d_rows_frozen", i), {28'd0, rows_n}, {28'd0, exp_rows});
                repeat (100) @(negedge clk);
                check($sformatf("v%0d_rows_after_hold", i), {28'd0, rows_n}, {28'd0, exp_rows});
                check($sformatf("v%0d_held_after_hold", i), {31'd0, key_held}, 32'd1);
                p_on = 1'b0;
                wait_held(1'b0, 200, $sformatf("v%0d_held_fall", i));
                exp_rows = ~(4'b0001 << ((vecs[i].row + 1) % 4));
                check($sformatf("v%0d_rows_resume", i), {28'd0, rows_n}, {28'd0, exp_rows});
                check($sformatf("v%0d_q_empty", i), exp_q.size(), 32'd0);
            end else begin
                seen = 4'd0;
                repeat (64) begin
                    @(negedge clk);
                    seen = seen | ~rows_n;
                end
                check($sformatf("v%0d_rows_advance", i), {28'd0, seen}, 32'hF);
                check($sformatf("v%0d_no_held", i), {31'd0, key_held}, 32'd0);
                p_on = 1'b0;
            end
            repeat (10) @(negedge clk);
        end

        // Asynchronous reset while a key is held.
        p_row = 2'd1; p_mask = 4'b0100; p_on = 1'b1;
        exp_q.push_back(6);
        wait_held(1'b1, 200, "arst_held_rise");
        #2 reset = 1'b0;
        #1;
        check("arst_rows_n", {28'd0, rows_n}, 32'hE);
        check("arst_key_code", {28'd0, key_code}, 32'd0);
        check("arst_key_valid", {31'd0, key_valid}, 32'd0);
        check("arst_key_held", {31'd0, key_held}, 32'd0);
        p_on = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("arst_no_held_after", {31'd0, key_held}, 32'd0);
        check("arst_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
